egress_drain: RTL and testbench
===============================

// Module: egress_drain
// PURPOSE
// Reader end of the D0/D1 destination FIFOs: pops both FIFOs under round-robin arbitration and
// merges the words into one valid/ready output stream tagged with the source port.
// Checks each word's dest bit against the port it came from and keeps per-port delivered counts.
// Sits after f_d0/f_d1 and replaces bench-driven D0_rd/D1_rd.
// PARAMETERS
// BW        6  data word width, same as the FIFOs
// CNT_W     8  width of each per-port delivered counter
// DEST_BIT  4  bit index of the destination field in a word (0 = D0, 1 = D1)
// PORTS
// clk          in   1      single clock, all state on rising edge
// reset        in   1      asynchronous, active-high reset
// D0_empty     in   1      D0 FIFO empty
// D0_data_out  in   BW     D0 FIFO read data, valid the cycle after D0_rd
// D0_rd        out  1      D0 FIFO pop, combinational, one-cycle pulse
// D1_empty     in   1      D1 FIFO empty
// D1_data_out  in   BW     D1 FIFO read data, valid the cycle after D1_rd
// D1_rd        out  1      D1 FIFO pop, combinational, one-cycle pulse
// sink_ready   in   1      downstream accepts out_data this cycle
// out_valid    out  1      out_data/out_port hold a word
// out_data     out  BW     merged word
// out_port     out  1      source FIFO of out_data (0 = D0, 1 = D1)
// D0_count     out  CNT_W  words delivered from D0 (saturating)
// D1_count     out  CNT_W  words delivered from D1 (saturating)
// dest_error   out  1      sticky: a word's DEST_BIT did not match its source port
// BEHAVIOUR
// - Reset: all outputs 0, FSM = IDLE, last_served = D1 (so D0 wins the first tie). Async assert,
//   sync release. A word popped but not yet delivered when reset asserts is lost, by design.
// - FSM states: IDLE, WAIT, HOLD. At most one read outstanding.
//   IDLE: if any FIFO is non-empty, pulse the rd of the chosen port and go to WAIT. Otherwise stay.
//   WAIT: the FIFO data is valid this cycle. Register it into out_data and record out_port.
//     out_valid rises next cycle. Go to HOLD. No rd is issued in WAIT.
//   HOLD: out_valid=1, and out_data/out_port stay stable until handshake (out_valid & sink_ready).
//     On handshake: increment the count of out_port, then:
//       if a FIFO is non-empty, pulse its rd in the same cycle and go to WAIT;
//       otherwise go to IDLE.
//     Without handshake: stay in HOLD, no rd.
// - Latency: rd in cycle t, out_valid in cycle t+2.
// - Throughput: one word per 2 cycles when sink_ready is held high.
// - Arbitration: if only one FIFO is non-empty, pick it. If both are, pick !last_served.
//   last_served updates on every rd issued.
// - rd is never asserted while the matching *_empty is 1. D0_rd and D1_rd are never high together.
// - Counters saturate at 2^CNT_W-1 (no wrap) and update only on handshake.
// - dest_error: set in WAIT if data[DEST_BIT] != port. It stays set until reset.
// - sink_ready with out_valid=0 is ignored.
// CONFIGURATION
// DRAIN_ERR_DROP_EN defined:
//   - A mismatched word still sets dest_error but is discarded in WAIT and never presented.
//   - The FSM goes to IDLE; counters are unchanged.
//   - Extra output err_count [CNT_W] counts drops, saturating, reset 0.
// DRAIN_ERR_DROP_EN undefined:
//   - A mismatched word is forwarded normally and counted, and sets dest_error. No err_count port.
// TESTING
// 1. Reset, then D0 holds 0x05 (dest=0) and D1 is empty, sink_ready=1 -> D0_rd pulses once;
//    out_valid=1, out_data=0x05, out_port=0 two cycles later; D0_count=1.
// 2. Both FIFOs hold 3 words with correct dest, sink_ready=1 -> order D0,D1,D0,D1,D0,D1;
//    D0_count=3, D1_count=3; rd pulses exactly 2 cycles apart; rd never asserted on an empty FIFO.
// 3. Word in HOLD with sink_ready=0 for 5 cycles -> out_data stable, no rd, counts unchanged;
//    raising sink_ready delivers it and issues the next rd in the same cycle.
// 4. D1 presents 0x00 (dest=0 from D1) -> dest_error=1 and stays 1.
//    Without the macro: word forwarded with out_port=1.
//    With DRAIN_ERR_DROP_EN: never forwarded, err_count=1, D1_count=0.
// 5. Assert reset while in WAIT -> all outputs 0 immediately; after release, the first tie goes to D0.
// 6. CNT_W=2, deliver 5 words from D0 -> D0_count sticks at 3.

Source files
------------

// File: rtl/egress_drain_if.sv
// Bundle of the FIFO read ports, merged output stream and status of the
// egress drain. The master modport is the drain itself; slave is its
// environment (the two FIFOs plus the downstream sink).
// err_count exists only when DRAIN_ERR_DROP_EN is defined.
interface egress_drain_if #(
  parameter int BW    = 6,
  parameter int CNT_W = 8
);
  logic             D0_empty;
  logic [BW-1:0]    D0_data_out;
  logic             D0_rd;
  logic             D1_empty;
  logic [BW-1:0]    D1_data_out;
  logic             D1_rd;
  logic             sink_ready;
  logic             out_valid;
  logic [BW-1:0]    out_data;
  logic             out_port;
  logic [CNT_W-1:0] D0_count;
  logic [CNT_W-1:0] D1_count;
  logic             dest_error;
`ifdef DRAIN_ERR_DROP_EN
  logic [CNT_W-1:0] err_count;
`endif

  modport master (
`ifdef DRAIN_ERR_DROP_EN
    output err_count,
`endif
    input  D0_empty, D0_data_out, D1_empty, D1_data_out, sink_ready,
    output D0_rd, D1_rd, out_valid, out_data, out_port,
    output D0_count, D1_count, dest_error
  );

  modport slave (
`ifdef DRAIN_ERR_DROP_EN
    input  err_count,
`endif
    output D0_empty, D0_data_out, D1_empty, D1_data_out, sink_ready,
    input  D0_rd, D1_rd, out_valid, out_data, out_port,
    input  D0_count, D1_count, dest_error
  );
endinterface

// File: rtl/egress_drain.sv
// Egress drain: reader end of the D0/D1 destination FIFOs. Pops both FIFOs
// under round-robin arbitration (one read outstanding at a time), merges the
// words into one valid/ready stream tagged with the source port, flags words
// whose destination bit disagrees with their source FIFO, and keeps
// saturating per-port delivered counts.
// Optional feature macro: DRAIN_ERR_DROP_EN -- when defined, mismatched words
// are discarded instead of forwarded and counted on err_count.
module egress_drain #(
  parameter int BW       = 6,
  parameter int CNT_W    = 8,
  parameter int DEST_BIT = 4
) (
  input logic            clk,
  input logic            reset,
  egress_drain_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state_q;
  logic             lastServed_q;
  logic             readPort_q;
  logic             outValid_q;
  logic             outPort_q;
  logic [BW-1:0]    outData_q;
  logic [CNT_W-1:0] d0Count_q;
  logic [CNT_W-1:0] d1Count_q;
  logic             destError_q;
`ifdef DRAIN_ERR_DROP_EN
  logic [CNT_W-1:0] errCount_q;
`endif

  logic          anyAvail;
  logic          pickPort_d;
  logic          handshake;
  logic          issueRd_d;
  logic [BW-1:0] readData;
  logic          wordBad;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Arbitration: a lone non-empty FIFO wins; on a tie the port not served last wins.
  assign anyAvail   = !bus.D0_empty || !bus.D1_empty;
  assign pickPort_d = (!bus.D0_empty && !bus.D1_empty) ? !lastServed_q : bus.D0_empty;
  assign handshake  = (state_q == HOLD) && bus.sink_ready;
  assign issueRd_d  = !reset && anyAvail && ((state_q == IDLE) || handshake);

  assign bus.D0_rd = issueRd_d && !pickPort_d;
  assign bus.D1_rd = issueRd_d &&  pickPort_d;

  // The FIFO answers one cycle after the pop, so the source port is remembered.
  assign readData = readPort_q ? bus.D1_data_out : bus.D0_data_out;
  assign wordBad  = readData[DEST_BIT] != readPort_q;

  assign bus.out_valid  = outValid_q;
  assign bus.out_data   = outData_q;
  assign bus.out_port   = outPort_q;
  assign bus.D0_count   = d0Count_q;
  assign bus.D1_count   = d1Count_q;
  assign bus.dest_error = destError_q;
`ifdef DRAIN_ERR_DROP_EN
  assign bus.err_count  = errCount_q;
`endif

  // Read/present FSM with all stream outputs, counters and error flags registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lastServed_q <= 1'b1;
      readPort_q   <= 1'b0;
      outValid_q   <= 1'b0;
      outPort_q    <= 1'b0;
      outData_q    <= '0;
      d0Count_q    <= '0;
      d1Count_q    <= '0;
      destError_q  <= 1'b0;
`ifdef DRAIN_ERR_DROP_EN
      errCount_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (issueRd_d) begin
            readPort_q   <= pickPort_d;
            lastServed_q <= pickPort_d;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (wordBad) begin
            destError_q <= 1'b1;
          end
`ifdef DRAIN_ERR_DROP_EN
          if (wordBad) begin
            errCount_q <= satInc(errCount_q);
            state_q    <= IDLE;
          end else begin
            outData_q  <= readData;
            outPort_q  <= readPort_q;
            outValid_q <= 1'b1;
            state_q    <= HOLD;
          end
`else
          outData_q  <= readData;
          outPort_q  <= readPort_q;
          outValid_q <= 1'b1;
          state_q    <= HOLD;
`endif
        end
        HOLD: begin
          if (handshake) begin
            outValid_q <= 1'b0;
            if (outPort_q) begin
              d1Count_q <= satInc(d1Count_q);
            end else begin
              d0Count_q <= satInc(d0Count_q);
            end
            if (issueRd_d) begin
              readPort_q   <= pickPort_d;
              lastServed_q <= pickPort_d;
              state_q      <= WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_egress_drain.sv
// Self-checking bench for egress_drain. Two FIFOs are modelled as queues;
// a scoreboard of popped words, per-port delivery counts, a sticky error
// flag and the round-robin rule form the reference. A second instance with
// CNT_W=2 shares all inputs to exercise counter saturation.
module tb_egress_drain;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  egress_drain_if #(.BW(6), .CNT_W(8)) bus ();
  egress_drain_if #(.BW(6), .CNT_W(2)) busS ();

  egress_drain #(.BW(6), .CNT_W(8), .DEST_BIT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  egress_drain #(.BW(6), .CNT_W(2), .DEST_BIT(4)) dutSmall (
    .clk(clk), .reset(reset), .bus(busS.master)
  );

  assign busS.D0_empty    = bus.D0_empty;
  assign busS.D1_empty    = bus.D1_empty;
  assign busS.D0_data_out = bus.D0_data_out;
  assign busS.D1_data_out = bus.D1_data_out;
  assign busS.sink_ready  = bus.sink_ready;

  typedef struct packed {
    logic       port;
    logic [5:0] data;
  } word_t;

  typedef struct {
    logic       port;
    logic [5:0] data;
    logic       expPort;
    logic [5:0] expData;
    int         expD0;
    int         expD1;
  } vec_t;

  int         compared = 0;
  int         mismatched = 0;
  int         tickNo = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  word_t      expQ[$];
  int         cnt0, cnt1, drops;
  bit         expErr, lastRd, holdPending;
  logic [5:0] heldData;
  logic       heldPort;
  logic       rdS0 = 1'b0, rdS1 = 1'b0, empS0 = 1'b1, empS1 = 1'b1;
  int         rdTick[$];
  bit         rdPortLog[$];
  vec_t       vecs[6];

  // Capture what the DUT saw at each rising edge: the pop requests and FIFO status.
  always @(posedge clk) begin
    rdS0  <= bus.D0_rd;
    rdS1  <= bus.D1_rd;
    empS0 <= bus.D0_empty;
    empS1 <= bus.D1_empty;
  end

  function automatic int sat(input int v, input int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", name, actual, expected, tickNo);
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    cnt0 = 0;
    cnt1 = 0;
    drops = 0;
    expErr = 0;
    lastRd = 1'b1;
    holdPending = 0;
  endtask

  task automatic noteRead(input logic port, input logic [5:0] d);
    word_t w;
    bit bad;
    bad = (d[4] != port);
    if (bad) expErr = 1;
    w.port = port;
    w.data = d;
`ifdef DRAIN_ERR_DROP_EN
    if (bad) drops++;
    else expQ.push_back(w);
`else
    expQ.push_back(w);
`endif
  endtask

  task automatic pushWord(input logic port, input logic [5:0] d);
    if (port) q1.push_back(d);
    else q0.push_back(d);
    bus.D0_empty = (q0.size() == 0);
    bus.D1_empty = (q1.size() == 0);
  endtask

  // One clock cycle: check state, serve last cycle's pop, set ready, score a handshake.
  task automatic applyStimulus(input bit ready);
    word_t w;
    logic [5:0] d;
    bit port, expPort;
    @(negedge clk);
    tickNo++;
    checkOutput("D0_count", 32'(bus.D0_count), sat(cnt0, 255));
    checkOutput("D1_count", 32'(bus.D1_count), sat(cnt1, 255));
    checkOutput("D0_count_sat2", 32'(busS.D0_count), sat(cnt0, 3));
    checkOutput("D1_count_sat2", 32'(busS.D1_count), sat(cnt1, 3));
    checkOutput("dest_error", 32'(bus.dest_error), 32'(expErr));
`ifdef DRAIN_ERR_DROP_EN
    checkOutput("err_count", 32'(bus.err_count), sat(drops, 255));
`endif
    if (holdPending) begin
      checkOutput("hold_valid", 32'(bus.out_valid), 1);
      checkOutput("hold_data", 32'(bus.out_data), 32'(heldData));
      checkOutput("hold_port", 32'(bus.out_port), 32'(heldPort));
    end
    checkOutput("rd_exclusive", 32'(rdS0 & rdS1), 0);
    if (rdS0 || rdS1) begin
      port = rdS1;
      checkOutput("rd_on_empty", 32'(port ? empS1 : empS0), 0);
      expPort = (!empS0 && !empS1) ? !lastRd : empS0;
      checkOutput("arb_port", 32'(port), 32'(expPort));
      lastRd = port;
      rdPortLog.push_back(port);
      rdTick.push_back(tickNo);
      d = '0;
      if (port && q1.size() > 0) begin
        d = q1.pop_front();
        bus.D1_data_out = d;
        noteRead(1'b1, d);
      end else if (!port && q0.size() > 0) begin
        d = q0.pop_front();
        bus.D0_data_out = d;
        noteRead(1'b0, d);
      end
    end
    bus.D0_empty = (q0.size() == 0);
    bus.D1_empty = (q1.size() == 0);
    bus.sink_ready = ready;
    holdPending = 0;
    if (bus.out_valid) begin
      if (ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", 1, 0);
          if (bus.out_port) cnt1++;
          else cnt0++;
        end else begin
          w = expQ.pop_front();
          checkOutput("sb_data", 32'(bus.out_data), 32'(w.data));
          checkOutput("sb_port", 32'(bus.out_port), 32'(w.port));
          if (w.port) cnt1++;
          else cnt0++;
        end
      end else begin
        holdPending = 1;
        heldData = bus.out_data;
        heldPort = bus.out_port;
      end
    end
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      applyStimulus(1'b1);
      done = (q0.size() == 0) && (q1.size() == 0) && (expQ.size() == 0) &&
             !bus.out_valid && !rdS0 && !rdS1;
    end
    if (!done) checkOutput("drain_timeout", 1, 0);
    applyStimulus(1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    checkOutput({tag, "_out_data"}, 32'(bus.out_data), 0);
    checkOutput({tag, "_out_port"}, 32'(bus.out_port), 0);
    checkOutput({tag, "_D0_rd"}, 32'(bus.D0_rd), 0);
    checkOutput({tag, "_D1_rd"}, 32'(bus.D1_rd), 0);
    checkOutput({tag, "_D0_count"}, 32'(bus.D0_count), 0);
    checkOutput({tag, "_D1_count"}, 32'(bus.D1_count), 0);
    checkOutput({tag, "_dest_error"}, 32'(bus.dest_error), 0);
  endtask

  // Bound on the whole run in case the DUT wedges somewhere unexpected.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    bit found, sawValid;
    int n, d1Before;
    logic [5:0] rd6;
    logic p;

    vecs[0] = '{1'b0, 6'h05, 1'b0, 6'h05, 1, 0};
    vecs[1] = '{1'b1, 6'h1A, 1'b1, 6'h1A, 1, 1};
    vecs[2] = '{1'b0, 6'h2F, 1'b0, 6'h2F, 2, 1};
    vecs[3] = '{1'b1, 6'h3F, 1'b1, 6'h3F, 2, 2};
    vecs[4] = '{1'b0, 6'h00, 1'b0, 6'h00, 3, 2};
    vecs[5] = '{1'b1, 6'h10, 1'b1, 6'h10, 3, 3};

    reset = 1'b1;
    bus.D0_empty = 1'b1;
    bus.D1_empty = 1'b1;
    bus.D0_data_out = '0;
    bus.D1_data_out = '0;
    bus.sink_ready = 1'b0;
    clearModel();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    #1;
    checkResetOutputs("reset");
    reset = 1'b0;

    // Single words, one at a time: latency, data, tag and running counts.
    for (int i = 0; i < 6; i++) begin
      pushWord(vecs[i].port, vecs[i].data);
      found = 0;
      n = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        applyStimulus(1'b1);
        n++;
        if (bus.out_valid) found = 1;
      end
      checkOutput("vec_latency", 32'(n), 2);
      checkOutput("vec_out_data", 32'(bus.out_data), 32'(vecs[i].expData));
      checkOutput("vec_out_port", 32'(bus.out_port), 32'(vecs[i].expPort));
      applyStimulus(1'b1);
      checkOutput("vec_D0_count", 32'(bus.D0_count), vecs[i].expD0);
      checkOutput("vec_D1_count", 32'(bus.D1_count), vecs[i].expD1);
    end

    // Both FIFOs loaded: strict alternation starting at D0, pops every 2 cycles.
    rdTick.delete();
    rdPortLog.delete();
    pushWord(1'b0, 6'h01);
    pushWord(1'b0, 6'h02);
    pushWord(1'b0, 6'h03);
    pushWord(1'b1, 6'h11);
    pushWord(1'b1, 6'h12);
    pushWord(1'b1, 6'h13);
    drain(60);
    checkOutput("rr_rd_count", 32'(rdPortLog.size()), 6);
    for (int i = 0; i < 6 && i < rdPortLog.size(); i++) begin
      checkOutput("rr_order", 32'(rdPortLog[i]), 32'(i % 2));
      if (i > 0) checkOutput("rr_spacing", 32'(rdTick[i] - rdTick[i-1]), 2);
    end
    checkOutput("rr_D0_count", 32'(bus.D0_count), 6);
    checkOutput("rr_D1_count", 32'(bus.D1_count), 6);
    checkOutput("sat2_D0_count", 32'(busS.D0_count), 3);

    // Backpressure: word held for 5 cycles, then release pops D1 in the same cycle.
    pushWord(1'b0, 6'h0A);
    pushWord(1'b1, 6'h15);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      applyStimulus(1'b0);
      if (bus.out_valid) found = 1;
    end
    checkOutput("bp_valid", 32'(found), 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0);
      checkOutput("bp_no_rd", 32'(rdS0 | rdS1), 0);
      checkOutput("bp_data", 32'(bus.out_data), 32'h0A);
    end
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("bp_next_rd_d1", 32'(rdS1), 1);
    drain(40);

    // Destination mismatch: D1 delivers a word tagged for D0.
    d1Before = cnt1;
    pushWord(1'b1, 6'h00);
`ifdef DRAIN_ERR_DROP_EN
    sawValid = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1);
      if (bus.out_valid) sawValid = 1;
    end
    checkOutput("drop_not_forwarded", 32'(sawValid), 0);
    checkOutput("drop_err_count", 32'(bus.err_count), 1);
    checkOutput("drop_D1_count", 32'(bus.D1_count), 32'(d1Before));
`else
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      applyStimulus(1'b1);
      if (bus.out_valid) found = 1;
    end
    checkOutput("mis_forwarded", 32'(found), 1);
    checkOutput("mis_out_port", 32'(bus.out_port), 1);
    checkOutput("mis_out_data", 32'(bus.out_data), 0);
    sawValid = 0;
`endif
    checkOutput("mis_dest_error", 32'(bus.dest_error), 1);
    drain(20);
    checkOutput("mis_dest_error_sticky", 32'(bus.dest_error), 1);

    // Reset while a pop is outstanding; the first tie afterwards goes to D0.
    pushWord(1'b0, 6'h01);
    pushWord(1'b0, 6'h02);
    pushWord(1'b1, 6'h11);
    applyStimulus(1'b1);
    checkOutput("rst_wait_rd_seen", 32'(rdS0), 1);
    reset = 1'b1;
    clearModel();
    #1;
    checkResetOutputs("rst_wait");
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    reset = 1'b0;
    found = 0;
    for (int k = 0; k < 5 && !found; k++) begin
      applyStimulus(1'b1);
      if (rdS0 || rdS1) found = 1;
    end
    checkOutput("rst_first_tie_d0", 32'(rdS0), 1);
    drain(40);

    // Randomized traffic against the scoreboard, with occasional bad tags.
    for (int k = 0; k < 800; k++) begin
      applyStimulus($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        p = 1'($urandom_range(0, 1));
        rd6 = 6'($urandom);
        rd6[4] = ($urandom_range(0, 7) == 0) ? !p : p;
        pushWord(p, rd6);
      end
    end
    drain(1000);
    checkOutput("final_expq_empty", 32'(expQ.size()), 0);
    checkOutput("final_D0_count", 32'(bus.D0_count), sat(cnt0, 255));
    checkOutput("final_D1_count", 32'(bus.D1_count), sat(cnt1, 255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
